dds_sweep_ctrl: RTL and testbench



---
 rtl/dds_sweep_ctrl.sv | 155 +++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller for a DDS: steps a tuning word from cfg_start to cfg_stop
// with per-word dwell, in single, repeating-sawtooth or triangle mode.
module dds_sweep_ctrl #(
  parameter int FW = 11,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] cfg_start,
  input  logic [FW-1:0] cfg_stop,
  input  logic [FW-1:0] cfg_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [1:0]    cfg_mode,
  input  logic [2:0]    cfg_wave,
  output logic [FW-1:0] freq_word,
  output logic [2:0]    wave_type,
  output logic          busy,
  output logic          done,
  output logic          wrap,
  output logic          cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;

  state_t        state;
  logic [FW-1:0] start_q, stop_q, step_q;
  logic [DW-1:0] dwell_q, dwell_cnt;
  logic [1:0]    mode_q;
  logic          dir_up;  // current direction of travel
  logic          fwd;     // on the start->stop leg (target is stop_q)

  logic [FW-1:0] target, next_word;
  logic          at_target, flip, cfg_bad;

  // One step from cur toward tgt, clamped to tgt when it would reach, pass, or wrap.
  function automatic logic [FW-1:0] step_toward(input logic [FW-1:0] cur,
                                                input logic          up,
                                                input logic [FW-1:0] stp,
                                                input logic [FW-1:0] tgt);
    logic [FW:0] sum;
    if (up) begin
      sum = {1'b0, cur} + {1'b0, stp};
      if (sum >= {1'b0, tgt}) return tgt;
    end else begin
      sum = {1'b0, cur} - {1'b0, stp};
      if (sum[FW] || sum <= {1'b0, tgt}) return tgt;
    end
    return sum[FW-1:0];
  endfunction

  assign cfg_bad = ((cfg_step == '0) && (cfg_start != cfg_stop)) ||
                   (cfg_mode == 2'd3) || (cfg_wave > 3'd4);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    target    = fwd ? stop_q : start_q;
    at_target = (freq_word == target);
    flip      = 1'b0;
    next_word = step_toward(freq_word, dir_up, step_q, target);
    if (at_target) begin
      if (mode_q == MODE_SAW) begin
        next_word = start_q;
      end else begin
        // Triangle turnaround: the endpoint has dwelt once, head back the other way.
        next_word = step_toward(freq_word, ~dir_up, step_q, fwd ? start_q : stop_q);
        flip      = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      freq_word <= '0;
      wave_type <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
      cfg_err   <= 1'b0;
      dwell_cnt <= '0;
      dir_up    <= 1'b1;
      fwd       <= 1'b1;
      // NOTE: the config shadow is a handful of flops, not a RAM, so it is reset with everything else.
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      mode_q    <= '0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (abort) begin
            freq_word <= '0;
          end else if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              start_q   <= cfg_start;
              stop_q    <= cfg_stop;
              step_q    <= cfg_step;
              dwell_q   <= cfg_dwell;
              mode_q    <= cfg_mode;
              freq_word <= cfg_start;
              wave_type <= cfg_wave;
              dwell_cnt <= cfg_dwell;
              dir_up    <= (cfg_start <= cfg_stop);
              fwd       <= 1'b1;
              cfg_err   <= 1'b0;
              busy      <= 1'b1;
              state     <= RUN;
            end
          end
        end

        RUN: begin
          if (abort) begin
            freq_word <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - DW'(1);
          end else if ((mode_q == MODE_SINGLE) && at_target) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            freq_word <= next_word;
            dwell_cnt <= dwell_q;
            wrap      <= (mode_q != MODE_SINGLE) && (next_word == start_q);
            if (flip) begin
              fwd    <= ~fwd;
              dir_up <= ~dir_up;
            end
          end
        end

        DONE: begin
          if (abort) freq_word <= '0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: a word-list model expands each sweep into per-cycle expectations
// that a negedge compare process checks against the DUT.
module tb_dds_sweep_ctrl;

  localparam int FW = 11;
  localparam int DW = 16;

  logic          clk, resetn, start, abort;
  logic [FW-1:0] cfg_start, cfg_stop, cfg_step;
  logic [DW-1:0] cfg_dwell;
  logic [1:0]    cfg_mode;
  logic [2:0]    cfg_wave;
  logic [FW-1:0] freq_word;
  logic [2:0]    wave_type;
  logic          busy, done, wrap, cfg_err;

  dds_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .cfg_wave(cfg_wave),
    .freq_word(freq_word), .wave_type(wave_type), .busy(busy),
    .done(done), .wrap(wrap), .cfg_err(cfg_err)
  );

  typedef struct {
    int fw;
    int wt;
    bit busy;
    bit done;
    bit wrap;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_err = 0;
  int   last_wv = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  function automatic void push(int fw, int wt, bit b, bit d, bit w, bit e);
    exp_t x;
    x.fw = fw; x.wt = wt; x.busy = b; x.done = d; x.wrap = w; x.err = e;
    exp_q.push_back(x);
  endfunction

  // Compare process: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("freq_word", freq_word, e.fw);
      check("wave_type", wave_type, e.wt);
      check("busy",      busy,      e.busy);
      check("done",      done,      e.done);
      check("wrap",      wrap,      e.wrap);
      check("cfg_err",   cfg_err,   e.err);
    end
  end

  // Model: list the words of one sweep period, then expand by dwell and mode.
  task automatic build_model(input int s, input int p, input int st, input int dw,
                             input int md, input int wv, input int hz);
    int words[$];
    int period[$];
    int w, n, k;
    bit up, fin;
    up = (s <= p);
    w = s;
    words.push_back(w);
    while (w != p) begin
      if (up) w = (w + st >= p) ? p : w + st;
      else    w = (w - st <= p) ? p : w - st;
      words.push_back(w);
    end
    period = words;
    if (md == 2) begin
      w = p;
      fin = 0;
      while (!fin) begin
        if (up) w = (w - st <= s) ? s : w - st;
        else    w = (w + st >= s) ? s : w + st;
        if (w == s) fin = 1;
        else period.push_back(w);
      end
    end
    if (md == 0) begin
      foreach (words[i])
        for (int r = 0; r <= dw; r++) push(words[i], wv, 1, 0, 0, 0);
      push(p, wv, 0, 1, 0, 0);
      push(p, wv, 0, 0, 0, 0);
    end else begin
      n = 0;
      k = 0;
      while (n < hz) begin
        foreach (period[i])
          for (int r = 0; r <= dw; r++)
            if (n < hz) begin
              push(period[i], wv, 1, 0, (k > 0 && i == 0 && r == 0), 0);
              n++;
            end
        k++;
      end
    end
  endtask

  task automatic drive_cfg(input int s, input int p, input int st, input int dw,
                           input int md, input int wv);
    cfg_start = FW'(s);
    cfg_stop  = FW'(p);
    cfg_step  = FW'(st);
    cfg_dwell = DW'(dw);
    cfg_mode  = 2'(md);
    cfg_wave  = 3'(wv);
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 with the model queued.
  task automatic start_sweep(input int s, input int p, input int st, input int dw,
                             input int md, input int wv, input int hz);
    drive_cfg(s, p, st, dw, md, wv);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_err = 0;
    last_wv = wv;
    build_model(s, p, st, dw, md, wv, hz);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_abort(input int wv);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    push(0, wv, 0, 0, 0, exp_err);
    push(0, wv, 0, 0, 0, exp_err);
    wait_drain();
  endtask

  task automatic reject(input string name, input int s, input int p, input int st,
                        input int md, input int wv, input int hold_fw);
    drive_cfg(s, p, st, 1, md, wv);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_err = 1;
    check({name, "_err"},  cfg_err,   1);
    check({name, "_busy"}, busy,      0);
    check({name, "_fw"},   freq_word, hold_fw);
    check({name, "_wt"},   wave_type, last_wv);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_fw",   freq_word, 0);
    check("rst_wt",   wave_type, 0);
    check("rst_busy", busy,      0);
    check("rst_done", done,      0);
    check("rst_wrap", wrap,      0);
    check("rst_err",  cfg_err,   0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Single up sweep with dwell 2.
    start_sweep(10, 20, 4, 2, 0, 2, 0);
    check("pin_up_len",   exp_q.size(), 14);
    check("pin_up_w0",    exp_q[0].fw,  10);
    check("pin_up_w3",    exp_q[3].fw,  14);
    check("pin_up_w11",   exp_q[11].fw, 20);
    check("pin_up_done",  exp_q[12].done, 1);
    check("pin_up_busy",  exp_q[12].busy, 0);
    wait_drain();

    // Down sweep clamped onto the stop word.
    start_sweep(20, 3, 8, 0, 0, 1, 0);
    check("pin_dn_w2",   exp_q[2].fw,   4);
    check("pin_dn_w3",   exp_q[3].fw,   3);
    check("pin_dn_done", exp_q[4].done, 1);
    wait_drain();

    // Triangle.
    start_sweep(0, 6, 3, 0, 2, 3, 14);
    check("pin_tri_w2",    exp_q[2].fw,   6);
    check("pin_tri_w4",    exp_q[4].fw,   0);
    check("pin_tri_wrap4", exp_q[4].wrap, 1);
    check("pin_tri_wrap0", exp_q[0].wrap, 0);
    wait_drain();
    do_abort(3);

    // Sawtooth that would overflow past 2047.
    start_sweep(2000, 2047, 100, 1, 1, 0, 8);
    check("pin_ovf_w2",   exp_q[2].fw,   2047);
    check("pin_ovf_w4",   exp_q[4].fw,   2000);
    check("pin_ovf_wrap", exp_q[4].wrap, 1);
    wait_drain();
    do_abort(0);

    // Sawtooth downward that would underflow below 0.
    start_sweep(5, 0, 8, 0, 1, 4, 6);
    wait_drain();
    do_abort(4);

    // start == stop in each mode.
    start_sweep(7, 7, 0, 2, 1, 1, 9);
    check("pin_eq_wrap3", exp_q[3].wrap, 1);
    check("pin_eq_wrap6", exp_q[6].wrap, 1);
    wait_drain();
    do_abort(1);
    start_sweep(7, 7, 0, 1, 2, 1, 6);
    wait_drain();
    do_abort(1);
    start_sweep(7, 7, 0, 2, 0, 1, 0);
    wait_drain();

    // Rejected starts leave the word at 7 and set the sticky error.
    reject("rej_step0", 5, 9, 0, 0, 2, 7);
    reject("rej_mode3", 5, 9, 1, 3, 2, 7);
    reject("rej_wave5", 5, 9, 1, 0, 5, 7);
    repeat (3) push(7, 1, 0, 0, 0, 1);
    wait_drain();

    // Accepted start clears cfg_err; a second start and cfg changes mid-run change nothing.
    start_sweep(10, 20, 4, 2, 0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    drive_cfg(100, 200, 1, 0, 1, 3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();

    // abort wins over start, in RUN and in IDLE.
    start_sweep(0, 6, 3, 0, 2, 2, 5);
    wait_drain();
    drive_cfg(10, 20, 4, 0, 0, 1);
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    push(0, 2, 0, 0, 0, 0);
    push(0, 2, 0, 0, 0, 0);
    wait_drain();
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    push(0, 2, 0, 0, 0, 0);
    push(0, 2, 0, 0, 0, 0);
    wait_drain();

    // Reset in the middle of a sweep.
    start_sweep(0, 6, 3, 0, 2, 4, 100);
    repeat (5) @(posedge clk);
    #1;
    exp_q.delete();
    resetn = 1'b0;
    #1;
    check("mrst_fw",   freq_word, 0);
    check("mrst_wt",   wave_type, 0);
    check("mrst_busy", busy,      0);
    check("mrst_wrap", wrap,      0);
    check("mrst_done", done,      0);
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_err = 0;
    repeat (4) push(0, 0, 0, 0, 0, 0);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
